// File: rtl/stream_packetizer.sv
// stream_packetizer: drains N_CH first-word-fall-through sample FIFOs in
// round-robin order (filtered by en_mask) and serialises each sample as a
// byte frame {channel ID | sequence number, payload MSB-first} onto an
// 8-bit write queue, honouring the queue's almost-full backpressure.
module stream_packetizer #(
    parameter int N_CH     = 5,
    parameter int SAMPLE_W = 12,
    parameter int ID_W     = 3,
    parameter int ID_BASE  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*SAMPLE_W-1:0] in_data,
    input  logic [N_CH-1:0]          em,
    output logic [N_CH-1:0]          pp,
    input  logic [N_CH-1:0]          en_mask,
    input  logic                     full_write,
    output logic [7:0]               out_write,
    output logic                     ld_write,
    output logic                     busy,
    output logic [7-ID_W:0]          seq
);

    localparam int SEQ_W  = 8 - ID_W;
    localparam int NB     = (SAMPLE_W + 7) / 8;
    localparam int BUF_W  = NB * 8;
    localparam int BI_W   = (NB > 1) ? $clog2(NB) : 1;
    localparam int LAST_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    // Reject parameter sets that would alias channel IDs or use reserved ID 0
    generate
        if ((N_CH < 1) || (N_CH > 7) || (SAMPLE_W < 1) || (SAMPLE_W > 32) ||
            (ID_W < 1) || (ID_W > 7) || (ID_BASE == 0) ||
            (ID_BASE + N_CH - 1 >= (1 << ID_W))) begin : g_bad_params
            $error("stream_packetizer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [LAST_W-1:0]   last_r, last_nxt_s;
    logic [SEQ_W-1:0]    seq_r, seq_nxt_s;
    logic [BI_W-1:0]     byte_idx_r, byte_idx_nxt_s;
    logic [BUF_W-1:0]    buf_r, buf_nxt_s;
    logic [N_CH-1:0]     pp_r, pp_nxt_s;
    logic [7:0]          out_r, out_nxt_s;
    logic                ld_r, ld_nxt_s;
    logic                busy_r, busy_nxt_s;

    logic [N_CH-1:0]     elig_s;
    logic [LAST_W:0]     cand_raw_s;
    logic [LAST_W:0]     cand_sum_s;
    logic [LAST_W-1:0]   cand_s;
    logic                hit_s;
    logic                gnt_vld_s;
    logic [LAST_W-1:0]   gnt_s;
    logic [ID_W-1:0]     hdr_id_s;
    logic [7:0]          data_byte_s;

    assign elig_s      = en_mask & ~em;
    // last_r doubles as the ID of the frame in flight: it is only updated on grant
    assign hdr_id_s    = ID_W'(ID_BASE) + ID_W'(last_r);
    // Buffer is zero-extended to whole bytes, so bits above SAMPLE_W read as 0
    assign data_byte_s = 8'(buf_r >> {byte_idx_r, 3'b000});

    // Round-robin search: first eligible channel after last_r, modulo N_CH
    always_comb begin
        gnt_vld_s  = 1'b0;
        gnt_s      = '0;
        cand_raw_s = '0;
        cand_sum_s = '0;
        cand_s     = '0;
        hit_s      = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            cand_raw_s = {1'b0, last_r} + (LAST_W+1)'(k);
            cand_sum_s = (cand_raw_s >= (LAST_W+1)'(N_CH)) ?
                         (cand_raw_s - (LAST_W+1)'(N_CH)) : cand_raw_s;
            cand_s     = cand_sum_s[LAST_W-1:0];
            hit_s      = !gnt_vld_s && elig_s[cand_s];
            gnt_s      = hit_s ? cand_s : gnt_s;
            gnt_vld_s  = gnt_vld_s | hit_s;
        end
    end

    // Next-state and next-output logic for the IDLE/HDR/DATA sequencer
    always_comb begin
        state_nxt_s    = state_r;
        last_nxt_s     = last_r;
        seq_nxt_s      = seq_r;
        byte_idx_nxt_s = byte_idx_r;
        buf_nxt_s      = buf_r;
        pp_nxt_s       = '0;
        out_nxt_s      = out_r;
        ld_nxt_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gnt_vld_s) begin
                    pp_nxt_s    = N_CH'(1'b1) << gnt_s;
                    buf_nxt_s   = BUF_W'(in_data[gnt_s*SAMPLE_W +: SAMPLE_W]);
                    last_nxt_s  = gnt_s;
                    state_nxt_s = ST_HDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (!full_write) begin
                    out_nxt_s      = {hdr_id_s, seq_r};
                    ld_nxt_s       = 1'b1;
                    byte_idx_nxt_s = BI_W'(NB - 1);
                    state_nxt_s    = ST_DATA;
                end else begin
                    ld_nxt_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (!full_write) begin
                    out_nxt_s = data_byte_s;
                    ld_nxt_s  = 1'b1;
                    if (byte_idx_r == '0) begin
                        seq_nxt_s   = seq_r + SEQ_W'(1'b1);
                        state_nxt_s = ST_IDLE;
                    end else begin
                        byte_idx_nxt_s = byte_idx_r - BI_W'(1'b1);
                    end
                end else begin
                    ld_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            last_r     <= LAST_W'(N_CH - 1);
            seq_r      <= '0;
            byte_idx_r <= '0;
            buf_r      <= '0;
            pp_r       <= '0;
            out_r      <= 8'h00;
            ld_r       <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            last_r     <= last_nxt_s;
            seq_r      <= seq_nxt_s;
            byte_idx_r <= byte_idx_nxt_s;
            buf_r      <= buf_nxt_s;
            pp_r       <= pp_nxt_s;
            out_r      <= out_nxt_s;
            ld_r       <= ld_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign pp        = pp_r;
    assign out_write = out_r;
    assign ld_write  = ld_r;
    assign busy      = busy_r;
    assign seq       = seq_r;

endmodule

// File: tb/tb_stream_packetizer.sv
// Testbench for stream_packetizer: FIFO emulation, transaction-level
// reference model feeding a byte scoreboard, directed and random stimulus.
module tb_stream_packetizer;

    localparam int N_CH     = 5;
    localparam int SAMPLE_W = 12;
    localparam int ID_W     = 3;
    localparam int ID_BASE  = 1;
    localparam int SEQ_W    = 8 - ID_W;
    localparam int NB       = (SAMPLE_W + 7) / 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_CH*SAMPLE_W-1:0] in_data;
    logic [N_CH-1:0]          em;
    logic [N_CH-1:0]          pp;
    logic [N_CH-1:0]          en_mask;
    logic                     full_write;
    logic [7:0]               out_write;
    logic                     ld_write;
    logic                     busy;
    logic [SEQ_W-1:0]         seq;

    logic [39:0] in20;
    logic [1:0]  em20, pp20, mask20;
    logic [7:0]  out20;
    logic        ld20, busy20;
    logic [4:0]  seq20;

    stream_packetizer #(.N_CH(N_CH), .SAMPLE_W(SAMPLE_W), .ID_W(ID_W), .ID_BASE(ID_BASE)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .em(em), .pp(pp), .en_mask(en_mask),
        .full_write(full_write), .out_write(out_write), .ld_write(ld_write),
        .busy(busy), .seq(seq)
    );

    stream_packetizer #(.N_CH(2), .SAMPLE_W(20), .ID_W(3), .ID_BASE(1)) u_dut20 (
        .clk(clk), .rst(rst), .in_data(in20), .em(em20), .pp(pp20), .en_mask(mask20),
        .full_write(1'b0), .out_write(out20), .ld_write(ld20),
        .busy(busy20), .seq(seq20)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bytes_seen = 0;
    int pp0_seen = 0;
    bit mon_on = 1'b0;

    int unsigned fifo_q[N_CH][$];
    int unsigned m_q[N_CH][$];
    int          m_last;
    int          m_seq;
    logic [7:0]  exp_q[$];
    int          hdr_q[$];
    int          hdr_cyc_q[$];
    int          byte_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fill(input int c, input int unsigned v);
        fifo_q[c].push_back(v);
        m_q[c].push_back(v);
    endtask

    // Transaction-level model: drain eligible channels round-robin, emit frames
    task automatic model_run(input logic [N_CH-1:0] mask);
        int g;
        bit found;
        int unsigned s;
        forever begin
            found = 1'b0;
            g = 0;
            for (int k = 1; k <= N_CH; k++) begin
                int c;
                c = (m_last + k) % N_CH;
                if (!found && mask[c] && m_q[c].size() > 0) begin
                    found = 1'b1;
                    g = c;
                end
            end
            if (!found) break;
            s = m_q[g].pop_front();
            m_last = g;
            exp_q.push_back(8'(((ID_BASE + g) << SEQ_W) | m_seq));
            for (int b = NB - 1; b >= 0; b--) exp_q.push_back(8'(s >> (8 * b)));
            m_seq = (m_seq + 1) % (1 << SEQ_W);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en_mask = '0;
        full_write = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            fifo_q[i].delete();
            m_q[i].delete();
        end
        exp_q.delete();
        hdr_q.delete();
        hdr_cyc_q.delete();
        byte_cyc_q.delete();
        m_last = N_CH - 1;
        m_seq = 0;
    endtask

    task automatic wait_pp(input int budget, output int pcyc);
        int n;
        n = 0;
        pcyc = -1;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (pp !== '0) begin
                pcyc = cyc;
                break;
            end
        end
        if (pcyc < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_pp: got no pop strobe, expected one within %0d cycles", budget);
        end
    endtask

    task automatic drain(input bit rand_bp, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            full_write = rand_bp ? ($urandom_range(0, 3) == 0) : 1'b0;
            n++;
        end while (!(exp_q.size() == 0 && busy === 1'b0) && n < budget);
        full_write = 1'b0;
        chk("drain_left", exp_q.size(), 0);
        chk("drain_busy", busy, 1'b0);
    endtask

    // FIFO emulation: pop on strobe, present head word and empty flags
    initial begin : fifo_model
        em = '1;
        in_data = '0;
        forever begin
            @(negedge clk);
            if (mon_on && pp !== '0) begin
                chk("pp_onehot", $onehot(pp), 1'b1);
                chk("pp_masked", pp & ~en_mask, 0);
                for (int i = 0; i < N_CH; i++) begin
                    if (pp[i]) begin
                        if (i == 0) pp0_seen = 1;
                        chk("pp_nonempty", fifo_q[i].size() > 0, 1'b1);
                        if (fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
                    end
                end
            end
            for (int i = 0; i < N_CH; i++) begin
                em[i] = (fifo_q[i].size() == 0);
                in_data[i*SAMPLE_W +: SAMPLE_W] = (fifo_q[i].size() > 0) ? SAMPLE_W'(fifo_q[i][0]) : '0;
            end
        end
    end

    // Output monitor: scoreboard compare of every written byte, hold check
    initial begin : monitor
        logic [7:0] prev_out;
        bit prev_rst;
        int pos;
        pos = 0;
        prev_rst = 1'b1;
        prev_out = 8'h00;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (ld_write === 1'b1) begin
                    bytes_seen++;
                    byte_cyc_q.push_back(cyc);
                    if (pos == 0) begin
                        hdr_q.push_back(int'(out_write));
                        hdr_cyc_q.push_back(cyc);
                    end
                    pos = (pos == NB) ? 0 : pos + 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no write (cycle %0d)", out_write, cyc);
                    end else begin
                        chk("byte", out_write, exp_q.pop_front());
                    end
                end else if (!prev_rst) begin
                    chk("out_hold", out_write, prev_out);
                end
                if (rst) pos = 0;
            end
            prev_rst = rst;
            prev_out = out_write;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int p, h, bs, got;
        logic [19:0] s20;
        logic [7:0]  exp20[4];
        int rr_exp[6];
        rr_exp = '{32'h20, 32'h41, 32'h62, 32'h83, 32'hA4, 32'h25};
        rst = 1'b1;
        en_mask = '0;
        full_write = 1'b0;
        mask20 = 2'b00;
        in20 = '0;
        em20 = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        mon_on = 1'b1;
        do_reset();

        // Reset state
        chk("rst_pp", pp, 0);
        chk("rst_ld", ld_write, 1'b0);
        chk("rst_out", out_write, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_seq", seq, 0);
        chk("rst_ld20", ld20, 1'b0);

        // SAMPLE_W=20 variant: three payload bytes, top nibble zero
        mask20 = 2'b01;
        for (int f = 0; f < 2; f++) begin
            s20 = (f == 0) ? 20'hFEDCB : 20'($urandom);
            exp20[0] = 8'((1 << 5) | f);
            exp20[1] = 8'(s20 >> 16);
            exp20[2] = 8'(s20 >> 8);
            exp20[3] = 8'(s20);
            in20[19:0] = s20;
            em20 = 2'b10;
            got = 0;
            for (int n = 0; n < 40 && got < 4; n++) begin
                @(negedge clk);
                if (pp20[0]) em20 = 2'b11;
                if (ld20) begin
                    chk("w20_byte", out20, exp20[got]);
                    got++;
                end
            end
            chk("w20_count", got, 4);
            @(posedge clk);
            #1;
        end
        mask20 = 2'b00;

        // Single channel, latency
        do_reset();
        en_mask = 5'b00010;
        fill(1, 32'hABC);
        h = cyc;
        model_run(en_mask);
        wait_pp(20, p);
        chk("single_pp", pp, 5'b00010);
        chk("pp_latency", p, h + 1);
        @(posedge clk);
        #1;
        chk("pp_width", pp, 0);
        drain(1'b0, 50);
        chk("single_nbytes", byte_cyc_q.size(), 3);
        chk("single_hdr", hdr_q[0], 32'h40);
        chk("hdr_latency", hdr_cyc_q[0], p + 1);
        chk("payload1_cyc", byte_cyc_q[1], p + 2);
        chk("payload2_cyc", byte_cyc_q[2], p + 3);
        chk("single_seq", seq, 1);

        // Round robin, all channels always non-empty
        do_reset();
        en_mask = 5'b11111;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < N_CH; c++) fill(c, $urandom_range(0, 4095));
        model_run(en_mask);
        drain(1'b0, 200);
        for (int i = 0; i < 6; i++) chk("rr_hdr", hdr_q[i], rr_exp[i]);
        for (int i = 1; i < 10; i++) chk("rr_period", hdr_cyc_q[i] - hdr_cyc_q[i-1], 4);

        // Backpressure on the first payload byte for 3 cycles
        do_reset();
        en_mask = 5'b00001;
        fill(0, 32'h5A3);
        model_run(en_mask);
        wait_pp(20, p);
        h = p + 1;
        @(posedge clk);
        #1;
        full_write = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        full_write = 1'b0;
        drain(1'b0, 50);
        chk("bp_nbytes", byte_cyc_q.size(), 3);
        chk("bp_hdr_cyc", byte_cyc_q[0], h);
        chk("bp_p1_cyc", byte_cyc_q[1], h + 4);
        chk("bp_p2_cyc", byte_cyc_q[2], h + 5);

        // Masked channel never popped
        do_reset();
        pp0_seen = 0;
        en_mask = 5'b00100;
        fill(0, 32'h111);
        fill(2, 32'h222);
        model_run(en_mask);
        drain(1'b0, 50);
        chk("mask_hdr", hdr_q[0], 32'h60);
        chk("mask_pp0", pp0_seen, 0);
        chk("mask_ch0_left", fifo_q[0].size(), 1);

        // Sequence wrap over 33 frames
        do_reset();
        en_mask = 5'b00001;
        for (int i = 0; i < 33; i++) fill(0, $urandom_range(0, 4095));
        model_run(en_mask);
        drain(1'b0, 400);
        chk("wrap_hdr32", hdr_q[31], 32'h3F);
        chk("wrap_hdr33", hdr_q[32], 32'h20);

        // Reset in the cycle after the header
        do_reset();
        en_mask = 5'b00001;
        fill(0, 32'hC35);
        model_run(en_mask);
        wait_pp(20, p);
        @(posedge clk);
        @(posedge clk);
        #1;
        do_reset();
        bs = bytes_seen;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_mid_nowrite", bytes_seen - bs, 0);
        chk("rst_mid_seq", seq, 0);
        chk("rst_mid_busy", busy, 1'b0);
        en_mask = 5'b00001;
        fill(0, 32'h0F0);
        model_run(en_mask);
        drain(1'b0, 50);
        chk("rst_mid_hdr", hdr_q[0], 32'h20);

        // Random masks, fills and backpressure
        do_reset();
        for (int r = 0; r < 30; r++) begin
            en_mask = N_CH'($urandom_range(1, 31));
            for (int c = 0; c < N_CH; c++) begin
                int n;
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) fill(c, $urandom_range(0, 4095));
            end
            model_run(en_mask);
            drain(1'b1, 1000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
